// File: rtl/iq_sweep_pkg.sv
// Shared types and constants for the IQ frequency-sweep controller.
package iq_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    OUTPUT  = 2'd3
  } sweep_state_t;

  localparam int PHASE_W_DEF = 32;
  localparam int DATA_W_DEF  = 14;

  // Sum of 2^acc_log2 signed data_w samples fits in data_w + acc_log2 bits.
  function automatic int acc_width(input int data_w, input int acc_log2);
    return data_w + acc_log2;
  endfunction

endpackage

// File: rtl/iq_avg_accum.sv
// Dual-channel signed accumulator: sums 2^ACC_LOG2 enabled samples and
// presents the arithmetic-shift average of each channel.
module iq_avg_accum
  import iq_sweep_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ACC_LOG2 = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_i,
  input  logic signed [DATA_W-1:0] i_q,
  output logic        [DATA_W-1:0] o_avg_i,
  output logic        [DATA_W-1:0] o_avg_q,
  output logic                     o_cnt_done
);

  localparam int ACC_W = acc_width(DATA_W, ACC_LOG2);
  localparam int CNT_W = ACC_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << ACC_LOG2) - 1);

  logic signed [ACC_W-1:0] r_acc_i;
  logic signed [ACC_W-1:0] r_acc_q;
  logic        [CNT_W-1:0] r_cnt;
  logic signed [ACC_W-1:0] w_ext_i;
  logic signed [ACC_W-1:0] w_ext_q;

  assign w_ext_i = ACC_W'(i_i);
  assign w_ext_q = ACC_W'(i_q);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_acc_i <= '0;
      r_acc_q <= '0;
      r_cnt   <= '0;
    end else if (i_en) begin
      r_acc_i <= r_acc_i + w_ext_i;
      r_acc_q <= r_acc_q + w_ext_q;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // High when the next enabled sample completes the set.
  assign o_cnt_done = (r_cnt == CNT_LAST);
  assign o_avg_i    = DATA_W'(r_acc_i >>> ACC_LOG2);
  assign o_avg_q    = DATA_W'(r_acc_q >>> ACC_LOG2);

endmodule

// File: rtl/iq_sweep_controller.sv
// Steps the NCO phase increment across a sweep, settles, averages I/Q per point.
// Optional IQ_SWEEP_PINGPONG_EN: sweep bounces between start and stop until abort.
module iq_sweep_controller
  import iq_sweep_pkg::*;
#(
  parameter int PHASE_W  = PHASE_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ACC_LOG2 = 4,
  parameter int SETTLE_W = 16,
  parameter int INDEX_W  = 16
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [PHASE_W-1:0]  cfg_phase_start,
  input  logic [PHASE_W-1:0]  cfg_phase_stop,
  input  logic [PHASE_W-1:0]  cfg_phase_step,
  input  logic [SETTLE_W-1:0] cfg_settle,
  output logic [PHASE_W-1:0]  phase_inc,
  input  logic                iq_valid,
  input  logic [DATA_W-1:0]   i_in,
  input  logic [DATA_W-1:0]   q_in,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_W-1:0]   res_i,
  output logic [DATA_W-1:0]   res_q,
  output logic [INDEX_W-1:0]  res_index,
  output logic                res_last,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state
);

  sweep_state_t        r_state;
  sweep_state_t        w_next;
  logic [PHASE_W-1:0]  r_phase_inc;
  logic [PHASE_W-1:0]  r_stop;
  logic [PHASE_W-1:0]  r_step;
  logic [SETTLE_W-1:0] r_settle_cfg;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic [INDEX_W-1:0]  r_index;
  logic                r_done;

  logic                w_start_acc;
  logic                w_handshake;
  logic                w_settle_zero;
  logic                w_acc_en;
  logic                w_acc_clr;
  logic                w_cnt_done;
  logic [PHASE_W:0]    w_sum_up;
  logic                w_last_up;
  logic                w_last;
  logic [DATA_W-1:0]   w_avg_i;
  logic [DATA_W-1:0]   w_avg_q;

  // Result handshake: res_valid rises in OUTPUT and holds with res_* stable;
  // a transfer happens on any clock edge where res_valid and res_ready are both high.
  assign w_start_acc   = (r_state == IDLE) && start;
  assign w_handshake   = (r_state == OUTPUT) && res_ready;
  assign w_settle_zero = (r_settle_cnt == '0);
  assign w_acc_en      = (r_state == CAPTURE) && iq_valid;
  assign w_acc_clr     = abort || w_start_acc || w_handshake;

  assign w_sum_up  = {1'b0, r_phase_inc} + {1'b0, r_step};
  assign w_last_up = (w_sum_up > {1'b0, r_stop}) || (r_step == '0);

`ifdef IQ_SWEEP_PINGPONG_EN
  logic [PHASE_W-1:0] r_start;
  logic               r_dir_down;
  logic [PHASE_W:0]   w_sum_dn;
  logic               w_last_dn;
  logic               w_go_down;

  assign w_sum_dn  = {1'b0, r_start} + {1'b0, r_step};
  assign w_last_dn = ({1'b0, r_phase_inc} < w_sum_dn) || (r_step == '0);
  assign w_last    = r_dir_down ? w_last_dn : w_last_up;
  assign w_go_down = r_dir_down ^ w_last;
`else
  assign w_last    = w_last_up || (r_index == '1);
`endif

  always_ff @(posedge CLK) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_next = SETTLE;
        SETTLE:  if (w_settle_zero) w_next = CAPTURE;
        CAPTURE: if (w_acc_en && w_cnt_done) w_next = OUTPUT;
        OUTPUT: begin
`ifdef IQ_SWEEP_PINGPONG_EN
          if (res_ready) w_next = SETTLE;
`else
          if (res_ready) w_next = w_last ? IDLE : SETTLE;
`endif
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset || abort) begin
      r_phase_inc  <= '0;
      r_stop       <= '0;
      r_step       <= '0;
      r_settle_cfg <= '0;
      r_settle_cnt <= '0;
      r_index      <= '0;
      r_done       <= 1'b0;
`ifdef IQ_SWEEP_PINGPONG_EN
      r_start      <= '0;
      r_dir_down   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_start_acc) begin
        r_phase_inc  <= cfg_phase_start;
        r_stop       <= cfg_phase_stop;
        r_step       <= cfg_phase_step;
        r_settle_cfg <= cfg_settle;
        r_settle_cnt <= cfg_settle;
        r_index      <= '0;
`ifdef IQ_SWEEP_PINGPONG_EN
        r_start      <= cfg_phase_start;
        r_dir_down   <= 1'b0;
`endif
      end else if ((r_state == SETTLE) && !w_settle_zero) begin
        r_settle_cnt <= r_settle_cnt - 1'b1;
      end else if (w_handshake) begin
`ifdef IQ_SWEEP_PINGPONG_EN
        r_dir_down   <= w_go_down;
        r_phase_inc  <= w_go_down ? (r_phase_inc - r_step) : (r_phase_inc + r_step);
        r_index      <= r_index + 1'b1;
        r_settle_cnt <= r_settle_cfg;
`else
        if (w_last) begin
          r_done <= 1'b1;
        end else begin
          r_phase_inc  <= r_phase_inc + r_step;
          r_index      <= r_index + 1'b1;
          r_settle_cnt <= r_settle_cfg;
        end
`endif
      end
    end
  end

  iq_avg_accum #(
    .DATA_W   (DATA_W),
    .ACC_LOG2 (ACC_LOG2)
  ) u_accum (
    .i_clk      (CLK),
    .i_reset    (reset),
    .i_clr      (w_acc_clr),
    .i_en       (w_acc_en),
    .i_i        (i_in),
    .i_q        (q_in),
    .o_avg_i    (w_avg_i),
    .o_avg_q    (w_avg_q),
    .o_cnt_done (w_cnt_done)
  );

  assign phase_inc = r_phase_inc;
  assign res_valid = (r_state == OUTPUT);
  assign res_i     = res_valid ? w_avg_i : '0;
  assign res_q     = res_valid ? w_avg_q : '0;
  assign res_index = r_index;
  assign res_last  = res_valid && w_last;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_iq_sweep_controller.sv
// Directed bench for iq_sweep_controller (ACC_LOG2 = 2) with a result scoreboard.
module tb_iq_sweep_controller;

  localparam int EW = 32 + 14 + 14 + 16 + 1;

  logic        CLK = 1'b0;
  logic        reset, start, abort;
  logic [31:0] cfg_phase_start, cfg_phase_stop, cfg_phase_step;
  logic [15:0] cfg_settle;
  logic [31:0] phase_inc;
  logic        iq_valid = 1'b1;
  logic [13:0] i_in = '0, q_in = '0;
  logic        res_valid, res_ready, res_last, busy, done;
  logic [13:0] res_i, res_q;
  logic [15:0] res_index;
  logic [1:0]  dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int cyc      = 0;
  int done_cyc = -1;
  int last_hs_cyc = -100;

  logic        gap_mode = 1'b0;
  logic        use_tbl  = 1'b0;
  logic        take     = 1'b0;
  int          tbl_idx  = 0;
  logic [13:0] const_i  = 14'd8;
  logic [13:0] const_q  = -14'sd8;
  logic [13:0] tbl_i[4];
  logic [13:0] tbl_q[4];

  iq_sweep_controller #(
    .PHASE_W(32), .DATA_W(14), .ACC_LOG2(2), .SETTLE_W(16), .INDEX_W(16)
  ) dut (
    .CLK(CLK), .reset(reset), .start(start), .abort(abort),
    .cfg_phase_start(cfg_phase_start), .cfg_phase_stop(cfg_phase_stop),
    .cfg_phase_step(cfg_phase_step), .cfg_settle(cfg_settle),
    .phase_inc(phase_inc), .iq_valid(iq_valid), .i_in(i_in), .q_in(q_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_i(res_i), .res_q(res_q),
    .res_index(res_index), .res_last(res_last), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk_exp(input logic [31:0] ph, input logic [13:0] ri,
                                           input logic [13:0] rq, input logic [15:0] idx,
                                           input logic last);
    return {ph, ri, rq, idx, last};
  endfunction

  // sample driver: advances the table only when the previous sample was consumed
  always @(negedge CLK) take = (dbg_state == 2'd2) && iq_valid;
  always @(posedge CLK) begin
    #2;
    if (take) tbl_idx = tbl_idx + 1;
    iq_valid = gap_mode ? ~iq_valid : 1'b1;
    if (!iq_valid) begin
      i_in = 14'd1000;
      q_in = 14'd1000;
    end else if (use_tbl) begin
      i_in = tbl_i[tbl_idx % 4];
      q_in = tbl_q[tbl_idx % 4];
    end else begin
      i_in = const_i;
      q_in = const_q;
    end
  end

  // scoreboard monitor
  always @(negedge CLK) begin
    logic [EW-1:0] e;
    if (res_valid && res_ready && !reset && !abort) begin
      if (exp_q.size() == 0) begin
        check("extra_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("res_phase", phase_inc, e[76:45]);
        check("res_i",     res_i,     e[44:31]);
        check("res_q",     res_q,     e[30:17]);
        check("res_index", res_index, e[16:1]);
        check("res_last",  res_last,  e[0]);
      end
      if (res_last) last_hs_cyc = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic start_sweep(input logic [31:0] ps, input logic [31:0] pe,
                             input logic [31:0] pst, input logic [15:0] st);
    cfg_phase_start = ps;
    cfg_phase_stop  = pe;
    cfg_phase_step  = pst;
    cfg_settle      = st;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    cfg_phase_start = 32'h5555;
    cfg_phase_stop  = 32'h0;
    cfg_phase_step  = 32'd7;
    cfg_settle      = 16'd9;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    @(negedge CLK);
    while (busy && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(tag, busy, 0);
    @(posedge CLK); #1;
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    @(negedge CLK);
    while (!res_valid && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(tag, res_valid, 1);
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, input string tag);
    int n = 0;
    @(negedge CLK);
    while (dbg_state != st && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(tag, dbg_state, st);
  endtask

  task automatic push_basic();
    exp_q.push_back(mk_exp(32'd1000, 14'd8, -14'sd8, 16'd0, 1'b0));
    exp_q.push_back(mk_exp(32'd1100, 14'd8, -14'sd8, 16'd1, 1'b0));
    exp_q.push_back(mk_exp(32'd1200, 14'd8, -14'sd8, 16'd2, 1'b0));
    exp_q.push_back(mk_exp(32'd1300, 14'd8, -14'sd8, 16'd3, 1'b1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    cfg_phase_start = '0; cfg_phase_stop = '0; cfg_phase_step = '0; cfg_settle = '0;
    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;
    @(negedge CLK);
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_phase", phase_inc, 0);
    check("rst_done", done, 0);
    check("rst_index", res_index, 0);
    @(posedge CLK); #1;

`ifdef IQ_SWEEP_PINGPONG_EN
    begin
      int n = 0;
      exp_q.push_back(mk_exp(32'd0,   14'd8, -14'sd8, 16'd0, 1'b0));
      exp_q.push_back(mk_exp(32'd100, 14'd8, -14'sd8, 16'd1, 1'b0));
      exp_q.push_back(mk_exp(32'd200, 14'd8, -14'sd8, 16'd2, 1'b1));
      exp_q.push_back(mk_exp(32'd100, 14'd8, -14'sd8, 16'd3, 1'b0));
      exp_q.push_back(mk_exp(32'd0,   14'd8, -14'sd8, 16'd4, 1'b1));
      exp_q.push_back(mk_exp(32'd100, 14'd8, -14'sd8, 16'd5, 1'b0));
      start_sweep(32'd0, 32'd200, 32'd100, 16'd0);
      while (exp_q.size() != 0 && n < 500) begin
        @(negedge CLK);
        n++;
      end
      check("pp_results_left", exp_q.size(), 0);
      @(posedge CLK); #1 abort = 1'b1;
      @(posedge CLK); #1 abort = 1'b0;
      @(negedge CLK);
      check("pp_abort_busy", busy, 0);
      check("pp_abort_phase", phase_inc, 0);
      check("pp_no_done", n_done, 0);
    end
`else
    // basic four-point sweep
    push_basic();
    start_sweep(32'd1000, 32'd1300, 32'd100, 16'd3);
    wait_idle(300, "basic_timeout");
    check("basic_left", exp_q.size(), 0);
    check("basic_done_cnt", n_done, 1);
    check("basic_done_lat", done_cyc, last_hs_cyc + 1);
    @(negedge CLK);
    check("done_one_cycle", done, 0);
    @(posedge CLK); #1;

    // rounding toward -inf, also step = 0 gives a single point
    tbl_i[0] = -14'sd1; tbl_i[1] = -14'sd2; tbl_i[2] = -14'sd1; tbl_i[3] = -14'sd1;
    tbl_q[0] = 14'd3;   tbl_q[1] = 14'd3;   tbl_q[2] = 14'd3;   tbl_q[3] = 14'd2;
    tbl_idx = 0; use_tbl = 1'b1;
    @(posedge CLK); #1;
    exp_q.push_back(mk_exp(32'd777, -14'sd2, 14'd2, 16'd0, 1'b1));
    start_sweep(32'd777, 32'd5000, 32'd0, 16'd0);
    wait_idle(100, "round_timeout");
    check("round_left", exp_q.size(), 0);
    check("round_done_cnt", n_done, 2);
    use_tbl = 1'b0;

    // backpressure at point 1
    res_ready = 1'b0;
    push_basic();
    start_sweep(32'd1000, 32'd1300, 32'd100, 16'd3);
    wait_valid(100, "bp_p0_timeout");
    @(posedge CLK); #1 res_ready = 1'b1;
    @(posedge CLK); #1 res_ready = 1'b0;
    wait_valid(100, "bp_p1_timeout");
    check("bp_index", res_index, 1);
    const_i = 14'd100;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      check("bp_phase_hold", phase_inc, 32'd1100);
      check("bp_res_i_hold", res_i, 14'd8);
      check("bp_valid_hold", res_valid, 1);
    end
    const_i = 14'd8;
    @(posedge CLK); #1 res_ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("bp_phase_adv", phase_inc, 32'd1200);
    check("bp_valid_drop", res_valid, 0);
    wait_idle(300, "bp_timeout");
    check("bp_left", exp_q.size(), 0);

    // top of phase range: no wrap
    exp_q.push_back(mk_exp(32'hFFFFFF00, 14'd8, -14'sd8, 16'd0, 1'b0));
    exp_q.push_back(mk_exp(32'hFFFFFF80, 14'd8, -14'sd8, 16'd1, 1'b1));
    start_sweep(32'hFFFFFF00, 32'hFFFFFFFF, 32'h80, 16'd1);
    wait_idle(200, "wrap_timeout");
    check("wrap_left", exp_q.size(), 0);
    check("wrap_final_phase", phase_inc, 32'hFFFFFF80);

    // start above stop: single point at start
    exp_q.push_back(mk_exp(32'd500, 14'd8, -14'sd8, 16'd0, 1'b1));
    start_sweep(32'd500, 32'd100, 32'd10, 16'd0);
    wait_idle(100, "rev_timeout");
    check("rev_left", exp_q.size(), 0);
    check("rev_done_cnt", n_done, 5);

    // abort after two captured samples
    start_sweep(32'd1000, 32'd1300, 32'd100, 16'd3);
    wait_state(2'd2, 50, "abort_reach_capture");
    @(negedge CLK);
    @(posedge CLK); #1 abort = 1'b1;
    @(posedge CLK); #1 abort = 1'b0;
    @(negedge CLK);
    check("abort_busy", busy, 0);
    check("abort_valid", res_valid, 0);
    check("abort_phase", phase_inc, 0);
    check("abort_no_done", n_done, 5);
    @(posedge CLK); #1;
    push_basic();
    start_sweep(32'd1000, 32'd1300, 32'd100, 16'd3);
    wait_idle(300, "post_abort_timeout");
    check("post_abort_left", exp_q.size(), 0);
    check("post_abort_done", n_done, 6);

    // synchronous reset during SETTLE
    start_sweep(32'd1000, 32'd1300, 32'd100, 16'd3);
    wait_state(2'd1, 20, "reset_reach_settle");
    @(posedge CLK); #1 reset = 1'b1;
    @(posedge CLK); #1 reset = 1'b0;
    @(negedge CLK);
    check("rst2_busy", busy, 0);
    check("rst2_valid", res_valid, 0);
    check("rst2_phase", phase_inc, 0);
    @(posedge CLK); #1;

    // gapped valid: invalid cycles carry garbage that must not be counted
    tbl_i[0] = 14'd4;   tbl_i[1] = 14'd8;   tbl_i[2] = 14'd12;  tbl_i[3] = 14'd16;
    tbl_q[0] = -14'sd4; tbl_q[1] = -14'sd4; tbl_q[2] = -14'sd4; tbl_q[3] = -14'sd5;
    tbl_idx = 0; use_tbl = 1'b1; gap_mode = 1'b1;
    @(posedge CLK); #1;
    exp_q.push_back(mk_exp(32'd0,   14'd10, -14'sd5, 16'd0, 1'b0));
    exp_q.push_back(mk_exp(32'd100, 14'd10, -14'sd5, 16'd1, 1'b1));
    start_sweep(32'd0, 32'd100, 32'd100, 16'd0);
    wait_idle(200, "gap_timeout");
    check("gap_left", exp_q.size(), 0);
    check("gap_done_cnt", n_done, 7);
    gap_mode = 1'b0; use_tbl = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iq_sweep_controller.md
Name: iq_sweep_controller

Overview:
- Sequences one IQModule through a frequency sweep. For each point it drives the NCO phase increment, waits a programmable settle time for the FIR to flush, then averages 2^ACC_LOG2 valid I/Q samples.
- Emits one averaged I/Q result per point over a valid/ready handshake.
- Sits between the SW/KEY control logic and one IQModule, on the IQ clock domain (CLOCK_12).

Parameters:
- PHASE_W, 32, phase-increment width; matches the NCO phi_inc.
- DATA_W, 14, signed I/Q sample width.
- ACC_LOG2, 4, log2 of samples averaged per point (range 0..8).
- SETTLE_W, 16, settle-counter width.
- INDEX_W, 16, point-index width.

Ports:
- CLK  in  1  IQ domain clock.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse; accepted only in IDLE.
- abort  in  1  returns to IDLE from any state.
- cfg_phase_start  in  PHASE_W  first phase increment.
- cfg_phase_stop  in  PHASE_W  last allowed phase increment.
- cfg_phase_step  in  PHASE_W  increment added per point.
- cfg_settle  in  SETTLE_W  settle cycles after each phase change.
- phase_inc  out  PHASE_W  to IQModule.phaseInc.
- iq_valid  in  1  input sample qualifier (filter valid).
- i_in  in  DATA_W  signed I.
- q_in  in  DATA_W  signed Q.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts.
- res_i  out  DATA_W  averaged I, signed.
- res_q  out  DATA_W  averaged Q, signed.
- res_index  out  INDEX_W  point number, 0-based.
- res_last  out  1  final point of sweep.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the sweep completes normally.

Behaviour:
- Clocking and reset: one clock (CLK); reset is synchronous, active-high. On reset, and on abort, all outputs go to 0, state goes to IDLE, and accumulators and counters clear. abort has priority over every other event, including start on the same cycle.
- Config latch: cfg_* inputs are latched on the cycle start is accepted. Later changes have no effect until the next start.
- States:
  - IDLE -> SETTLE on start. phase_inc = cfg_phase_start on the next cycle. Settle counter loads cfg_settle and index = 0.
  - SETTLE: counter decrements each cycle; goes to CAPTURE on the cycle the counter is 0. With cfg_settle = 0, SETTLE lasts exactly 1 cycle. iq_valid is ignored in SETTLE.
  - CAPTURE: on each iq_valid, add sign-extended i_in/q_in into accumulators of width DATA_W+ACC_LOG2. After the 2^ACC_LOG2-th valid sample, go to OUTPUT.
  - OUTPUT: res_i/res_q = accumulator >>> ACC_LOG2 (arithmetic shift; truncates toward -inf). res_valid stays high and res_* stay stable until res_ready.
- OUTPUT on res_ready while res_valid:
  - If res_last: go to IDLE and pulse done on the same cycle.
  - Otherwise: phase_inc += step, index++, reload the settle counter, clear the accumulators, go to SETTLE.
- res_last rule: set when any of these hold:
  - the (PHASE_W+1)-bit sum phase_inc + step > cfg_phase_stop;
  - step == 0;
  - index == 2^INDEX_W - 1.
  - Consequences: start > stop gives a single point at start; the phase never wraps.
- Backpressure: no samples are captured while in OUTPUT, and phase_inc stays constant until the handshake.
- Latency per point: 1 + cfg_settle cycles of settle, plus 2^ACC_LOG2 valid samples, plus the handshake.
- start while busy is ignored. busy is 0 only in IDLE.

Optional Feature:
- Macro: IQ_SWEEP_PINGPONG_EN.
- When defined:
  - At the last point, instead of finishing, the direction reverses and phase_inc steps down by step toward cfg_phase_start, then reverses again at start. This repeats indefinitely until abort.
  - res_last pulses with each result at a turning point; done never pulses.
  - The down-going turn test is phase_inc < cfg_phase_start + step (also computed at PHASE_W+1 bits).
  - index keeps incrementing and wraps modulo 2^INDEX_W.
- When undefined: single up-sweep as described in Behaviour.

Decomposition:
- Package iq_sweep_pkg holds:
  - state enum (IDLE, SETTLE, CAPTURE, OUTPUT);
  - PHASE_W and DATA_W default constants;
  - a function giving accumulator width.
- One natural sub-module: iq_avg_accum. It is a dual-channel signed accumulate/shift unit with clear, enable and a count-done flag, instantiated once with ACC_LOG2.

Test Plan:
- Basic sweep: start=1000, stop=1300, step=100, settle=3, ACC_LOG2=2, iq_valid always high, i_in=8, q_in=-8, res_ready=1 -> 4 results, index 0..3, phase_inc 1000/1100/1200/1300, res_i=8, res_q=-8, res_last on index 3, done one cycle later than the final handshake.
- Rounding: samples i_in = -1, -2, -1, -1 with ACC_LOG2=2 -> res_i = -2 (sum -5 >>> 2).
- Backpressure: hold res_ready=0 for 10 cycles at point 1 -> res_* stable, phase_inc unchanged, no accumulation. Release -> phase_inc advances the next cycle.
- Edge configs:
  - step=0 -> exactly 1 result, with res_last.
  - start=0xFFFFFF00, stop=0xFFFFFFFF, step=0x80 -> results at 0xFFFFFF00 and 0xFFFFFF80 only, no wrap.
- Abort/reset: assert abort in CAPTURE after 2 samples -> next cycle busy=0, res_valid=0, phase_inc=0. A subsequent start gives a clean sweep. Synchronous reset asserted mid-SETTLE behaves the same.
- Gapped input: iq_valid toggling every other cycle with settle=0 -> exactly 2^ACC_LOG2 valid samples counted per point. Pingpong build: start=0, stop=200, step=100 -> phase_inc sequence 0,100,200,100,0,100…
